clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per display-digit step.
REQ-002 SHALL have parameter BLINK_DIV, default 12500000: clk cycles per blink toggle.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port key_mode, input, 1 bit: mode button, synchronous level, active-high.
REQ-006 SHALL have port key_next, input, 1 bit: next-digit button, synchronous level, active-high.
REQ-007 SHALL have port key_inc, input, 1 bit: increment button, synchronous level, active-high.
REQ-008 SHALL have port key_clr, input, 1 bit: clear button, synchronous level, active-high.
REQ-009 SHALL have port sel1, output, 4 bits: datapath write select; 0 means none, 1..6 selects sec-units, sec-tens, min-units, min-tens, hr-units, hr-tens.
REQ-010 SHALL have port data, output, 4 bits: digit value for the datapath.
REQ-011 SHALL have port ld_n, output, 1 bit: datapath load strobe, active-low.
REQ-012 SHALL have port clr_n, output, 1 bit: datapath clear strobe, active-low.
REQ-013 SHALL have port sel2, output, 4 bits: display digit select, 1..6 for hr-tens..sec-units.
REQ-014 SHALL have port blink, output, 1 bit: edit-cursor blink enable.

Function
REQ-015 SHALL detect key presses as 0->1 rising edges of registered key levels: one event per press, no event while a key is held.
REQ-016 SHALL have FSM states RUN, EDIT, COMMIT, LOAD.
REQ-017 In RUN: sel1=0, ld_n=1; a key_clr event drives clr_n=0 for exactly one cycle; a key_mode event enters EDIT with idx=1 and all six edit digits=0.
REQ-018 In EDIT: sel1=0; a key_next event sets idx to idx+1, wrapping 6->1.
REQ-019 In EDIT: a key_inc event increments digit[idx] modulo its limit: 10 for idx 1,3,5; 6 for idx 2,4; 3 for idx 6.
REQ-020 Hour rule: when hr-tens=2, hr-units SHALL wrap at 4; an increment that makes hr-tens 2 while hr-units>3 SHALL force hr-units to 0.
REQ-021 Simultaneous key events SHALL be resolved by priority mode > next > inc; lower-priority events in the same cycle are discarded. key_clr is ignored outside RUN.
REQ-022 In EDIT, a key_mode event SHALL enter COMMIT with k=1.
REQ-023 In COMMIT: sel1=k and data=digit[k] for one cycle each, k=1..6 (6 cycles), then the FSM enters LOAD.
REQ-024 In LOAD: sel1=0, ld_n=0 for exactly one cycle, then the FSM returns to RUN; COMMIT-to-RUN takes 7 cycles.
REQ-025 Outside COMMIT, data SHALL equal digit[idx].
REQ-026 Key events during COMMIT/LOAD SHALL be discarded.
REQ-027 sel2 SHALL step 1..6 and wrap every SCAN_DIV cycles in all states.
REQ-028 blink SHALL be 0 outside EDIT; in EDIT it toggles every BLINK_DIV cycles, starting at 1 on EDIT entry.

Reset
REQ-029 On rst_n=0 (asynchronous): state=RUN, sel1=0, data=0, ld_n=1, clr_n=1, sel2=1, blink=0, idx=1, digits=0, all dividers and edge registers cleared.
REQ-030 Reset asserted mid-COMMIT/LOAD SHALL abort the sequence with no ld_n pulse issued.

Structure
REQ-031 Shared package clock_ctrl_pkg SHALL hold the FSM state enum, digit-index constants 1..6, and the per-digit limits.
REQ-032 A sub-module key_edge (registered rising-edge detector) SHALL be instantiated once per key.

Verification
REQ-033 mode, next, inc x3, next x2, inc, mode -> COMMIT shows sel1=1..6 with data=0,3,0,1,0,0, then ld_n=0 for 1 cycle, then RUN.
REQ-034 In EDIT idx=6: inc x3 -> hr-tens 1,2,0; with hr-units=7, the inc to 2 -> hr-units=0.
REQ-035 key_mode and key_inc rise in the same cycle in EDIT -> COMMIT entered, digit unchanged.
REQ-036 key_clr held 10 cycles in RUN -> exactly one clr_n=0 cycle.
REQ-037 rst_n low at COMMIT k=3 -> all outputs at reset values, ld_n never low.
REQ-038 SCAN_DIV=4 -> sel2 sequence 1,2,3,4,5,6,1, each held 4 cycles.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock-setting controller: FSM states,
// digit indices (1 = sec-units .. 6 = hr-tens) and per-digit limits.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        EDIT,
        COMMIT,
        LOAD
    } state_t;

    localparam logic [2:0] IDX_SEC_U = 3'd1;
    localparam logic [2:0] IDX_SEC_T = 3'd2;
    localparam logic [2:0] IDX_MIN_U = 3'd3;
    localparam logic [2:0] IDX_MIN_T = 3'd4;
    localparam logic [2:0] IDX_HR_U  = 3'd5;
    localparam logic [2:0] IDX_HR_T  = 3'd6;

    localparam logic [3:0] LIM_UNITS      = 4'd10;
    localparam logic [3:0] LIM_TENS       = 4'd6;
    localparam logic [3:0] LIM_HR_T       = 4'd3;
    localparam logic [3:0] LIM_HR_U_AT_20 = 4'd4;

    // Wrap value of a digit; hr-units is limited to 0..3 while hr-tens is 2.
    function automatic logic [3:0] digit_limit(input logic [2:0] idx,
                                               input logic [3:0] hr_tens);
        case (idx)
            IDX_SEC_U, IDX_MIN_U: return LIM_UNITS;
            IDX_SEC_T, IDX_MIN_T: return LIM_TENS;
            IDX_HR_U:             return (hr_tens == 4'd2) ? LIM_HR_U_AT_20 : LIM_UNITS;
            IDX_HR_T:             return LIM_HR_T;
            default:              return LIM_UNITS;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_ctrl_key_edge.sv
// Registered rising-edge detector: one-cycle pulse per 0->1 key transition.
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic rise
);

    logic key_q;
    logic key_qq;

    // Two-stage key level history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= 1'b0;
            key_qq <= 1'b0;
        end else begin
            key_q  <= key;
            key_qq <= key_q;
        end
    end

    assign rise = key_q & ~key_qq;

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock-setting controller: edits six time digits from buttons, commits them
// to the datapath one digit per cycle, and drives display scan and blink.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_next,
    input  logic       key_inc,
    input  logic       key_clr,
    output logic [3:0] sel1,
    output logic [3:0] data,
    output logic       ld_n,
    output logic       clr_n,
    output logic [3:0] sel2,
    output logic       blink
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic ev_mode, ev_next, ev_inc, ev_clr;

    key_edge u_edge_mode (.clk(clk), .rst_n(rst_n), .key(key_mode), .rise(ev_mode));
    key_edge u_edge_next (.clk(clk), .rst_n(rst_n), .key(key_next), .rise(ev_next));
    key_edge u_edge_inc  (.clk(clk), .rst_n(rst_n), .key(key_inc),  .rise(ev_inc));
    key_edge u_edge_clr  (.clk(clk), .rst_n(rst_n), .key(key_clr),  .rise(ev_clr));

    state_t            state, state_nx;
    logic [2:0]        idx, idx_nx;
    logic [2:0]        k, k_nx;
    logic [6:1][3:0]   digit, digit_nx;
    logic [3:0]        cur, lim, inc_val;
    logic [SCAN_W-1:0] scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;

    // FSM and edit-register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            idx   <= IDX_SEC_U;
            k     <= IDX_SEC_U;
            digit <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            k     <= k_nx;
            digit <= digit_nx;
        end
    end

    // Next state, digit editing and datapath strobes; mode > next > inc.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        k_nx     = k;
        digit_nx = digit;
        sel1     = '0;
        data     = digit[idx];
        ld_n     = 1'b1;
        clr_n    = 1'b1;
        cur      = digit[idx];
        lim      = digit_limit(idx, digit[IDX_HR_T]);
        inc_val  = (cur + 4'd1 >= lim) ? '0 : cur + 4'd1;
        case (state)
            RUN: begin
                if (ev_clr) begin
                    clr_n = 1'b0;
                end
                if (ev_mode) begin
                    state_nx = EDIT;
                    idx_nx   = IDX_SEC_U;
                    digit_nx = '0;
                end
            end
            EDIT: begin
                if (ev_mode) begin
                    state_nx = COMMIT;
                    k_nx     = IDX_SEC_U;
                end else if (ev_next) begin
                    idx_nx = (idx == IDX_HR_T) ? IDX_SEC_U : idx + 3'd1;
                end else if (ev_inc) begin
                    digit_nx[idx] = inc_val;
                    if (idx == IDX_HR_T && inc_val == 4'd2 && digit[IDX_HR_U] > 4'd3) begin
                        digit_nx[IDX_HR_U] = '0;
                    end
                end
            end
            COMMIT: begin
                sel1 = {1'b0, k};
                data = digit[k];
                if (k == IDX_HR_T) begin
                    state_nx = LOAD;
                end else begin
                    k_nx = k + 3'd1;
                end
            end
            LOAD: begin
                ld_n     = 1'b0;
                state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    // Display digit scan, free-running in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            sel2     <= 4'd1;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            sel2     <= (sel2 == 4'd6) ? 4'd1 : sel2 + 4'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Edit-cursor blink: forced on at EDIT entry, off as soon as EDIT is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (state_nx != EDIT) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (state != EDIT) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl against a digit-level reference model.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, key_mode, key_next, key_inc, key_clr;
    logic [3:0] sel1, data, sel2;
    logic       ld_n, clr_n, blink;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: editing flag, cursor position and six digit values.
    bit m_edit;
    int m_idx;
    int m_dig[1:6];

    always #5 clk = ~clk;

    clock_set_ctrl #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_mode(key_mode), .key_next(key_next), .key_inc(key_inc), .key_clr(key_clr),
        .sel1(sel1), .data(data), .ld_n(ld_n), .clr_n(clr_n),
        .sel2(sel2), .blink(blink)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void model_reset();
        m_edit = 1'b0;
        m_idx  = 1;
        for (int i = 1; i <= 6; i++) m_dig[i] = 0;
    endfunction

    function automatic void model_inc();
        int lim;
        case (m_idx)
            2, 4:    lim = 6;
            6:       lim = 3;
            default: lim = 10;
        endcase
        if (m_idx == 5 && m_dig[6] == 2) lim = 4;
        m_dig[m_idx] = (m_dig[m_idx] + 1) % lim;
        if (m_idx == 6 && m_dig[6] == 2 && m_dig[5] > 3) m_dig[5] = 0;
    endfunction

    // One press-and-release of the chosen keys, mirrored into the model.
    task automatic press(bit mode, bit nxt, bit inc);
        key_mode = mode; key_next = nxt; key_inc = inc;
        step(2);
        key_mode = 0; key_next = 0; key_inc = 0;
        step(2);
        if (!m_edit) begin
            if (mode) begin
                m_edit = 1'b1;
                m_idx  = 1;
                for (int i = 1; i <= 6; i++) m_dig[i] = 0;
            end
        end else if (nxt) begin
            m_idx = m_idx % 6 + 1;
        end else if (inc) begin
            model_inc();
        end
    endtask

    task automatic check_edit_view(string tag);
        n_checks++;
        if (data !== 4'(m_dig[m_idx]) || sel1 !== 4'd0 || ld_n !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: data=%0d sel1=%0d ld_n=%0b, expected data=%0d sel1=0 ld_n=1",
                     tag, data, sel1, ld_n, m_dig[m_idx]);
        end
    endtask

    // Mode press in EDIT (optionally with inc rising together), then checks
    // the six-digit write-out, the load strobe and the return to RUN.
    task automatic commit_and_check(bit with_inc, string tag);
        int waited = 0;
        key_mode = 1'b1;
        key_inc  = with_inc;
        while (sel1 === 4'd0 && waited < 10) begin
            step();
            waited++;
        end
        n_checks++;
        if (sel1 !== 4'd1) begin
            n_fail++;
            $display("FAIL %s_start: sel1=%0d, expected 1 within 10 cycles", tag, sel1);
        end
        for (int k = 1; k <= 6; k++) begin
            n_checks++;
            if (sel1 !== 4'(k) || data !== 4'(m_dig[k]) || ld_n !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_digit%0d: sel1=%0d data=%0d ld_n=%0b, expected sel1=%0d data=%0d ld_n=1",
                         tag, k, sel1, data, ld_n, k, m_dig[k]);
            end
            step();
        end
        n_checks++;
        if (ld_n !== 1'b0 || sel1 !== 4'd0) begin
            n_fail++;
            $display("FAIL %s_load: ld_n=%0b sel1=%0d, expected ld_n=0 sel1=0", tag, ld_n, sel1);
        end
        step();
        n_checks++;
        if (ld_n !== 1'b1 || sel1 !== 4'd0 || blink !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_run: ld_n=%0b sel1=%0d blink=%0b, expected 1 0 0", tag, ld_n, sel1, blink);
        end
        key_mode = 1'b0;
        key_inc  = 1'b0;
        step(2);
        m_edit = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_mode = 0; key_next = 0; key_inc = 0; key_clr = 0;
        step(3);
        n_checks++;
        if (sel1 !== 4'd0 || data !== 4'd0 || ld_n !== 1'b1 || clr_n !== 1'b1 ||
            sel2 !== 4'd1 || blink !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: sel1=%0d data=%0d ld_n=%0b clr_n=%0b sel2=%0d blink=%0b, expected 0 0 1 1 1 0",
                     sel1, data, ld_n, clr_n, sel2, blink);
        end
        rst_n = 1'b1;
        model_reset();
        step(2);
    endtask

    task automatic test_clr_hold();
        int lows = 0;
        key_clr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (clr_n === 1'b0) lows++;
        end
        key_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (clr_n === 1'b0) lows++;
        end
        n_checks++;
        if (lows != 1) begin
            n_fail++;
            $display("FAIL clr_hold: clr_n low for %0d cycles, expected 1", lows);
        end
    endtask

    task automatic test_scan();
        logic [3:0] prev = sel2;
        int waited = 0;
        int start;
        while (sel2 === prev && waited < 10) begin
            step();
            waited++;
        end
        n_checks++;
        if (sel2 === prev) begin
            n_fail++;
            $display("FAIL scan_step: sel2=%0d, expected a change within 10 cycles", sel2);
        end
        start = int'(sel2);
        for (int n = 0; n < 7; n++) begin
            int v = (start - 1 + n) % 6 + 1;
            for (int c = 0; c < 4; c++) begin
                n_checks++;
                if (sel2 !== 4'(v)) begin
                    n_fail++;
                    $display("FAIL scan_seq: sel2=%0d, expected %0d (step %0d cycle %0d)", sel2, v, n, c);
                end
                step();
            end
        end
    endtask

    task automatic test_blink();
        int waited = 0;
        key_mode = 1'b1;
        while (blink !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        m_edit = 1'b1;
        m_idx  = 1;
        for (int i = 1; i <= 6; i++) m_dig[i] = 0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (blink !== ((i < 8) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL blink: blink=%0b at cycle %0d of EDIT, expected %0b", blink, i, (i < 8));
            end
            step();
        end
        key_mode = 1'b0;
        step(2);
        check_edit_view("blink_edit_data");
        commit_and_check(1'b0, "blink_commit");
    endtask

    task automatic test_spec_sequence();
        press(1, 0, 0);
        press(0, 1, 0);
        repeat (3) press(0, 0, 1);
        check_edit_view("seq_inc");
        repeat (2) press(0, 1, 0);
        press(0, 0, 1);
        check_edit_view("seq_inc2");
        commit_and_check(1'b0, "seq_commit");
    endtask

    task automatic test_hour_rule();
        int exp_ht[3] = '{1, 2, 0};
        int exp_hu[4] = '{1, 2, 3, 0};
        press(1, 0, 0);
        repeat (5) press(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            press(0, 0, 1);
            n_checks++;
            if (data !== 4'(exp_ht[i])) begin
                n_fail++;
                $display("FAIL hr_tens_wrap: data=%0d, expected %0d", data, exp_ht[i]);
            end
        end
        repeat (5) press(0, 1, 0);
        repeat (7) press(0, 0, 1);
        check_edit_view("hr_units7");
        press(0, 1, 0);
        press(0, 0, 1);
        press(0, 0, 1);
        repeat (5) press(0, 1, 0);
        n_checks++;
        if (data !== 4'd0) begin
            n_fail++;
            $display("FAIL hr_units_forced: data=%0d, expected 0", data);
        end
        for (int i = 0; i < 4; i++) begin
            press(0, 0, 1);
            n_checks++;
            if (data !== 4'(exp_hu[i])) begin
                n_fail++;
                $display("FAIL hr_units_wrap4: data=%0d, expected %0d", data, exp_hu[i]);
            end
        end
        commit_and_check(1'b0, "hour_commit");
    endtask

    task automatic test_priority();
        press(1, 0, 0);
        press(0, 0, 1);
        press(0, 0, 1);
        check_edit_view("prio_setup");
        press(0, 1, 1);
        check_edit_view("prio_next_over_inc");
        commit_and_check(1'b1, "prio_mode_over_inc");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            press(1, 0, 0);
            for (int i = 0; i < 15; i++) begin
                case ($urandom_range(0, 3))
                    0, 1:    press(0, 0, 1);
                    2:       press(0, 1, 0);
                    default: press(0, 1, 1);
                endcase
                check_edit_view("random_edit");
            end
            commit_and_check(1'($urandom_range(0, 1)), "random_commit");
        end
    endtask

    task automatic test_reset_abort();
        int waited = 0;
        int lows = 0;
        press(1, 0, 0);
        repeat (2) press(0, 0, 1);
        key_mode = 1'b1;
        while (sel1 !== 4'd3 && waited < 12) begin
            step();
            waited++;
        end
        n_checks++;
        if (sel1 !== 4'd3) begin
            n_fail++;
            $display("FAIL abort_reach_k3: sel1=%0d, expected 3", sel1);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sel1 !== 4'd0 || data !== 4'd0 || ld_n !== 1'b1 || clr_n !== 1'b1 ||
            sel2 !== 4'd1 || blink !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: sel1=%0d data=%0d ld_n=%0b clr_n=%0b sel2=%0d blink=%0b, expected 0 0 1 1 1 0",
                     sel1, data, ld_n, clr_n, sel2, blink);
        end
        key_mode = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            if (ld_n === 1'b0) lows++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ld_n === 1'b0) lows++;
        end
        n_checks++;
        if (lows != 0 || data !== 4'd0 || sel1 !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_no_load: ld_n low %0d cycles data=%0d sel1=%0d, expected 0 0 0", lows, data, sel1);
        end
    endtask

    initial begin
        test_reset();
        test_clr_hold();
        test_scan();
        test_blink();
        test_spec_sequence();
        test_hour_rule();
        test_priority();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
